// File: rtl/axi_rw_txn_scheduler.sv
// One-outstanding-transaction gate for the bridge's AXI slave port.
// Round-robin read/write arbitration, completion tracking and a sticky watchdog flag.
module axi_rw_txn_scheduler #(
  parameter bit          WR_FIRST       = 1'b1,
  parameter int unsigned TO_WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic S_AWVALID,
  output logic S_AWREADY,
  output logic M_AWVALID,
  input  logic M_AWREADY,
  input  logic S_WVALID,
  output logic S_WREADY,
  output logic M_WVALID,
  input  logic M_WREADY,
  input  logic S_ARVALID,
  output logic S_ARREADY,
  output logic M_ARVALID,
  input  logic M_ARREADY,
  input  logic BVALID,
  input  logic BREADY,
  input  logic RVALID,
  input  logic RREADY,
  input  logic RLAST,
  input  logic ERR_CLR,
  output logic BUSY,
  output logic GRANT_WR,
  output logic TIMEOUT_ERR
);

  localparam bit WD_EN = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [TO_WIDTH-1:0] WD_LAST =
    TO_WIDTH'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                last_wr;
  logic [TO_WIDTH-1:0] wd_cnt;
  logic                aw_hs;
  logic                ar_hs;
  logic                w_hs;
  logic                b_hs;
  logic                r_hs;
  logic                progress;
  logic                err_set;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (S_AWVALID && (!S_ARVALID || !last_wr)) state_nxt = WR_ADDR;
        else if (S_ARVALID)                         state_nxt = RD_ADDR;
      end
      WR_ADDR: if (S_AWVALID && M_AWREADY)         state_nxt = WR_RESP;
      WR_RESP: if (BVALID && BREADY)               state_nxt = IDLE;
      RD_ADDR: if (S_ARVALID && M_ARREADY)         state_nxt = RD_DATA;
      RD_DATA: if (RVALID && RREADY && RLAST)      state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // Handshake gating straight from the current state, no added latency
  always_comb begin
    M_AWVALID = 1'b0;
    S_AWREADY = 1'b0;
    M_WVALID  = 1'b0;
    S_WREADY  = 1'b0;
    M_ARVALID = 1'b0;
    S_ARREADY = 1'b0;
    BUSY      = (state != IDLE);
    GRANT_WR  = (state == WR_ADDR) || (state == WR_RESP);
    if (state == WR_ADDR) begin
      M_AWVALID = S_AWVALID;
      S_AWREADY = M_AWREADY;
    end
    if (GRANT_WR) begin
      M_WVALID = S_WVALID;
      S_WREADY = M_WREADY;
    end
    if (state == RD_ADDR) begin
      M_ARVALID = S_ARVALID;
      S_ARREADY = M_ARREADY;
    end
  end

  // Round-robin memory: remembers the direction of the last grant
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_wr <= ~WR_FIRST;
    end else if (state == IDLE) begin
      if (state_nxt == WR_ADDR)      last_wr <= 1'b1;
      else if (state_nxt == RD_ADDR) last_wr <= 1'b0;
    end
  end

  assign aw_hs    = (state == WR_ADDR) && S_AWVALID && M_AWREADY;
  assign ar_hs    = (state == RD_ADDR) && S_ARVALID && M_ARREADY;
  assign w_hs     = GRANT_WR && S_WVALID && M_WREADY;
  assign b_hs     = BVALID && BREADY;
  assign r_hs     = RVALID && RREADY;
  assign progress = aw_hs || ar_hs || w_hs || b_hs || r_hs;
  assign err_set  = WD_EN && (state != IDLE) && !progress && (wd_cnt == WD_LAST);

  // Stall counter: restarts on any channel progress, saturates otherwise
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wd_cnt <= '0;
    end else if (!WD_EN || (state == IDLE) || progress) begin
      wd_cnt <= '0;
    end else if (wd_cnt != '1) begin
      wd_cnt <= wd_cnt + TO_WIDTH'(1);
    end
  end

  // Sticky error; a new timeout outranks a simultaneous clear
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)     TIMEOUT_ERR <= 1'b0;
    else if (err_set) TIMEOUT_ERR <= 1'b1;
    else if (ERR_CLR) TIMEOUT_ERR <= 1'b0;
  end

endmodule

// File: tb/tb_axi_rw_txn_scheduler.sv
// Directed bench: two schedulers (write-first and read-first, 8-cycle watchdog) on shared stimulus.
module tb_axi_rw_txn_scheduler;

  localparam logic [10:0] AWV = 11'h400, AWR = 11'h200, WV = 11'h100, WR = 11'h080;
  localparam logic [10:0] ARV = 11'h040, ARR = 11'h020, BV = 11'h010, BR = 11'h008;
  localparam logic [10:0] RV  = 11'h004, RR  = 11'h002, RL = 11'h001;

  localparam logic [7:0] O_MAWV = 8'h80, O_SAWR = 8'h40, O_MWV  = 8'h20, O_SWR = 8'h10;
  localparam logic [7:0] O_MARV = 8'h08, O_SARR = 8'h04, O_BUSY = 8'h02, O_GWR = 8'h01;

  typedef struct {
    logic [10:0] in;
    logic [7:0]  exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [10:0] in_v;
  logic        err_clr;
  wire  [7:0]  o0;
  wire  [7:0]  o1;
  wire         err0;
  wire         err1;
  int          n_chk;
  int          n_pass;
  vec_t        tbl [11];

  axi_rw_txn_scheduler #(.WR_FIRST(1'b1), .TO_WIDTH(16), .TIMEOUT_CYCLES(8)) u0 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AWVALID(in_v[10]), .S_AWREADY(o0[6]), .M_AWVALID(o0[7]), .M_AWREADY(in_v[9]),
    .S_WVALID(in_v[8]),   .S_WREADY(o0[4]),  .M_WVALID(o0[5]),  .M_WREADY(in_v[7]),
    .S_ARVALID(in_v[6]),  .S_ARREADY(o0[2]), .M_ARVALID(o0[3]), .M_ARREADY(in_v[5]),
    .BVALID(in_v[4]), .BREADY(in_v[3]), .RVALID(in_v[2]), .RREADY(in_v[1]), .RLAST(in_v[0]),
    .ERR_CLR(err_clr), .BUSY(o0[1]), .GRANT_WR(o0[0]), .TIMEOUT_ERR(err0)
  );

  axi_rw_txn_scheduler #(.WR_FIRST(1'b0), .TO_WIDTH(16), .TIMEOUT_CYCLES(8)) u1 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AWVALID(in_v[10]), .S_AWREADY(o1[6]), .M_AWVALID(o1[7]), .M_AWREADY(in_v[9]),
    .S_WVALID(in_v[8]),   .S_WREADY(o1[4]),  .M_WVALID(o1[5]),  .M_WREADY(in_v[7]),
    .S_ARVALID(in_v[6]),  .S_ARREADY(o1[2]), .M_ARVALID(o1[3]), .M_ARREADY(in_v[5]),
    .BVALID(in_v[4]), .BREADY(in_v[3]), .RVALID(in_v[2]), .RREADY(in_v[1]), .RLAST(in_v[0]),
    .ERR_CLR(err_clr), .BUSY(o1[1]), .GRANT_WR(o1[0]), .TIMEOUT_ERR(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [10:0] v);
    in_v = v;
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    in_v    = '0;
    err_clr = 1'b0;
    rst_n   = 1'b0;

    // Single write: AW in cycle 0, AWREADY at 2, W beats at 1,3,4,5, B at 9
    tbl[0]  = '{AWV | WV | WR,  8'h00};
    tbl[1]  = '{AWV | WV | WR,  O_MAWV | O_MWV | O_SWR | O_BUSY | O_GWR};
    tbl[2]  = '{AWV | AWR | WR, O_MAWV | O_SAWR | O_SWR | O_BUSY | O_GWR};
    tbl[3]  = '{WV | WR,        O_MWV | O_SWR | O_BUSY | O_GWR};
    tbl[4]  = '{WV | WR,        O_MWV | O_SWR | O_BUSY | O_GWR};
    tbl[5]  = '{WV | WR,        O_MWV | O_SWR | O_BUSY | O_GWR};
    tbl[6]  = '{WR,             O_SWR | O_BUSY | O_GWR};
    tbl[7]  = '{WR | ARV,       O_SWR | O_BUSY | O_GWR};
    tbl[8]  = '{WR,             O_SWR | O_BUSY | O_GWR};
    tbl[9]  = '{WR | BV | BR,   O_SWR | O_BUSY | O_GWR};
    tbl[10] = '{WR,             8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("rst outs u0", 32'(o0), 32'h0);
    chk("rst outs u1", 32'(o1), 32'h0);
    chk("rst err u0", 32'(err0), 32'h0);
    rst_n = 1'b1;

    // Simultaneous AW+AR from reset, then again after completion
    drv(AWV | ARV);
    chk("arb idle u0", 32'(o0), 32'h0);
    step();
    chk("arb1 u0 write", 32'(o0), 32'(O_MAWV | O_BUSY | O_GWR));
    chk("arb1 u1 read", 32'(o1), 32'(O_MARV | O_BUSY));
    drv(AWV | ARV | AWR | ARR);
    step();
    drv(AWV | ARV | BV | BR | RV | RR | RL);
    step();
    drv(AWV | ARV);
    chk("arb gap u0", 32'(o0), 32'h0);
    chk("arb gap u1", 32'(o1), 32'h0);
    step();
    chk("arb2 u0 read", 32'(o0), 32'(O_MARV | O_BUSY));
    chk("arb2 u1 write", 32'(o1), 32'(O_MAWV | O_BUSY | O_GWR));
    drv(AWV | ARV | AWR | ARR);
    step();
    drv(BV | BR | RV | RR | RL);
    step();
    drv(11'h000);
    chk("arb done u0", 32'(o0), 32'h0);
    step();

    for (int i = 0; i < 11; i++) begin
      drv(tbl[i].in);
      chk($sformatf("wr[%0d] u0", i), 32'(o0), 32'(tbl[i].exp));
      chk($sformatf("wr[%0d] u1", i), 32'(o1), 32'(tbl[i].exp));
      @(posedge clk);
      #1;
    end

    // Read burst of 4 beats with a write request raised mid-burst
    drv(ARV);
    step();
    drv(ARV | ARR);
    chk("rd addr", 32'(o0), 32'(O_MARV | O_SARR | O_BUSY));
    step();
    for (int b = 0; b < 3; b++) begin
      drv(AWV | AWR | WV | WR | RV | RR);
      chk($sformatf("rd beat%0d", b + 1), 32'(o0), 32'(O_BUSY));
      step();
    end
    drv(AWV | AWR | WV | WR | RV | RR | RL);
    chk("rd last beat", 32'(o0), 32'(O_BUSY));
    step();
    drv(AWV);
    chk("rd idle gap", 32'(o0), 32'h0);
    step();
    chk("wr after rd u0", 32'(o0), 32'(O_MAWV | O_BUSY | O_GWR));
    chk("wr after rd u1", 32'(o1), 32'(O_MAWV | O_BUSY | O_GWR));
    drv(AWV | AWR);
    step();
    drv(BV | BR);
    step();
    drv(11'h000);
    step();

    // Watchdog: B withheld after the AW handshake
    drv(AWV);
    step();
    drv(AWV | AWR);
    step();
    drv(11'h000);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("wd quiet%0d", k), 32'(err0), 32'h0);
    end
    step();
    chk("wd set u0", 32'(err0), 32'h1);
    chk("wd set u1", 32'(err1), 32'h1);
    repeat (3) step();
    chk("wd sticky", 32'(err0), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wd clear", 32'(err0), 32'h0);
    repeat (3) step();
    chk("wd no reset", 32'(err0), 32'h0);
    drv(BV | BR);
    step();
    drv(11'h000);
    chk("wd late b idle", 32'(o0), 32'h0);

    // Set and clear in the same cycle: set wins
    drv(AWV);
    step();
    drv(AWV | AWR);
    step();
    drv(11'h000);
    repeat (7) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("set beats clr", 32'(err0), 32'h1);
    drv(BV | BR);
    step();
    drv(11'h000);
    step();

    // Asynchronous reset in RD_DATA
    drv(ARV);
    step();
    drv(ARV | ARR);
    step();
    drv(WV | WR);
    chk("rd data busy", 32'(o0), 32'(O_BUSY));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst outs", 32'(o0), 32'h0);
    chk("async rst err", 32'(err0), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(AWV | ARV);
    step();
    chk("post rst u0 write", 32'(o0), 32'(O_MAWV | O_BUSY | O_GWR));
    chk("post rst u1 read", 32'(o1), 32'(O_MARV | O_BUSY));
    drv(11'h000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_rw_txn_scheduler.md
Name: axi_rw_txn_scheduler

Overview:
- Sequences the single AXI slave port of the AXI-to-AHB-Lite bridge so that exactly one AXI transaction is outstanding at a time.
- Sits between the upstream AXI master and the bridge, and gates only the AW/AR/W valid/ready handshakes. Address, ID, len, size, burst and data buses route around it unchanged.
- Arbitrates read vs write round-robin and tracks each transaction to its completion (B response, or R beat with RLAST).
- Runs a completion watchdog and raises a sticky timeout error.

Parameters:
- WR_FIRST, 1, arbitration winner on the first simultaneous AW/AR after reset (1 = write wins, 0 = read wins).
- TO_WIDTH, 16, watchdog counter width.
- TIMEOUT_CYCLES, 1024, cycles without channel progress before TIMEOUT_ERR sets. 0 disables the watchdog. Must be < 2^TO_WIDTH.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AWVALID  in  1  upstream write address valid.
- S_AWREADY  out  1  upstream write address ready.
- M_AWVALID  out  1  bridge AWVALID.
- M_AWREADY  in  1  bridge AWREADY.
- S_WVALID  in  1  upstream write data valid.
- S_WREADY  out  1  upstream write data ready.
- M_WVALID  out  1  bridge WVALID.
- M_WREADY  in  1  bridge WREADY.
- S_ARVALID  in  1  upstream read address valid.
- S_ARREADY  out  1  upstream read address ready.
- M_ARVALID  out  1  bridge ARVALID.
- M_ARREADY  in  1  bridge ARREADY.
- BVALID, BREADY  in  1 each  write response handshake, monitored only.
- RVALID, RREADY, RLAST  in  1 each  read data handshake, monitored only.
- ERR_CLR  in  1  single-cycle pulse; clears TIMEOUT_ERR.
- BUSY  out  1  high in any state other than IDLE.
- GRANT_WR  out  1  high in WR_ADDR or WR_RESP.
- TIMEOUT_ERR  out  1  sticky watchdog flag.

Behaviour:
- Async reset (ARESETN=0) forces:
  - state = IDLE; last_wr = ~WR_FIRST; watchdog counter = 0;
  - TIMEOUT_ERR = 0, BUSY = 0, GRANT_WR = 0;
  - all M_*VALID and S_*READY = 0.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE arbitration, registered, so the grant takes effect the cycle after valid is seen:
  - only S_AWVALID high -> WR_ADDR;
  - only S_ARVALID high -> RD_ADDR;
  - both high -> WR_ADDR if last_wr = 0, else RD_ADDR.
  - last_wr updates on entry to WR_ADDR (=1) or RD_ADDR (=0).
- WR_ADDR:
  - M_AWVALID = S_AWVALID; S_AWREADY = M_AWREADY.
  - On S_AWVALID & M_AWREADY -> WR_RESP.
- W channel open only in WR_ADDR and WR_RESP: M_WVALID = S_WVALID, S_WREADY = M_WREADY. Else both are 0.
- WR_RESP: on BVALID & BREADY -> IDLE.
- RD_ADDR:
  - M_ARVALID = S_ARVALID; S_ARREADY = M_ARREADY.
  - On S_ARVALID & M_ARREADY -> RD_DATA.
- RD_DATA: on RVALID & RREADY & RLAST -> IDLE. Non-last beats do not change state.
- Ready/valid gating is combinational from state, with no added latency inside a granted phase.
- Minimum one IDLE cycle between completion and the next grant.
- Valid dropping in WR_ADDR/RD_ADDR (an upstream protocol violation): hold state and keep gating; no recovery.
- B/R activity while in IDLE or in the wrong phase: ignored, no state change.
- Watchdog (TIMEOUT_CYCLES ≠ 0):
  - Counter clears in IDLE and on any progress event: AW, AR, W, R or B handshake.
  - Otherwise it increments, saturating at 2^TO_WIDTH−1.
  - When the counter equals TIMEOUT_CYCLES−1 and no progress occurs that cycle, TIMEOUT_ERR sets next cycle.
  - The state machine is unaffected.
- TIMEOUT_ERR clear/set priority:
  - Clears the cycle after ERR_CLR.
  - If ERR_CLR coincides with a set condition, set wins.

Test Plan:
- Single write: AW held high with M_AWREADY high at cycle 2, 4 W beats, B at cycle 9 -> M_AWVALID first high cycle 1, WR_RESP at cycle 3, IDLE at cycle 10, BUSY high cycles 1–9.
- Simultaneous AW+AR from reset with WR_FIRST=1, then again after completion -> first grant is write (GRANT_WR=1), second is read. Repeat with WR_FIRST=0 -> order is read then write.
- Read burst ARLEN=3: R beats with RLAST only on beat 4, and an S_AWVALID raised mid-burst -> stays RD_DATA through beats 1–3; M_AWVALID=0 and S_WREADY=0 throughout; write granted 2 cycles after RLAST handshake.
- W before AW: S_WVALID high in IDLE -> S_WREADY=0 and M_WVALID=0 until WR_ADDR is entered.
- Watchdog with TIMEOUT_CYCLES=8: B never returned -> TIMEOUT_ERR rises 8 cycles after the AW handshake and stays high; ERR_CLR pulse clears it next cycle; later B still returns the block to IDLE.
- Reset mid-transaction: ARESETN low in RD_DATA -> all outputs 0 immediately (asynchronous); after release, state is IDLE and the first simultaneous request goes per WR_FIRST.
